// File: rtl/lsu_axi_sb.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_axi_sb
//  Purpose  : Load/store unit bridging core valid/ready requests to an
//             AXI4-Lite master, with a posted-store buffer and sign/zero
//             extension of load data.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_axi_sb #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int SB_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    // core request / response
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                store_err,
    output logic [ADDR_W-1:0]   store_err_addr,
    input  logic                err_clr,
    output logic                sb_empty,
    // AXI4-Lite write address / data / response
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    // AXI4-Lite read address / data
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready
);

    localparam int c_BYTES  = DATA_W / 8;
    localparam int c_LANE_W = $clog2(c_BYTES);
    localparam int c_PTR_W  = $clog2(SB_DEPTH);
    localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W + 1)'(SB_DEPTH);

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_BUSY = 1'b1} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2} r_state_t;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [c_LANE_W-1:0] w_lane;
    logic                w_illegal;
    logic                w_misal;
    logic                w_bad;
    logic                w_full;
    logic                w_sb_empty;
    logic                w_accept;
    logic                w_push;
    logic                w_ld_go;
    logic [c_BYTES-1:0]  w_size_mask;
    logic [c_BYTES-1:0]  w_st_strb;
    logic [DATA_W-1:0]   w_st_wdata;

    w_state_t            r_w_state, w_w_state_nxt;
    r_state_t            r_r_state, w_r_state_nxt;
    logic [c_PTR_W:0]    r_sb_count;
    logic [c_PTR_W-1:0]  r_sb_wptr, r_sb_rptr;
    logic                r_resp_valid;

    assign w_lane    = req_addr[c_LANE_W-1:0];
    assign w_illegal = (req_size == 2'd3) && (DATA_W == 32);

    always_comb begin
        w_misal = 1'b0;
        case (req_size)
            2'd0:    w_misal = 1'b0;
            2'd1:    w_misal = req_addr[0];
            2'd2:    w_misal = |req_addr[1:0];
            default: w_misal = |req_addr[2:0];
        endcase
    end

    assign w_bad      = w_illegal | w_misal;
    assign w_full     = (r_sb_count == c_FULL);
    assign w_sb_empty = (r_sb_count == '0) && (r_w_state == W_IDLE);

    // Loads wait for every posted store to finish: no forwarding path exists
    assign req_ready = (r_r_state == R_IDLE) && !r_resp_valid &&
                       (req_wen ? !w_full : w_sb_empty);

    assign w_accept = req_valid && req_ready;
    assign w_push   = w_accept && req_wen && !w_bad;
    assign w_ld_go  = w_accept && !req_wen && !w_bad;

    assign w_size_mask = ~({c_BYTES{1'b1}} << (4'd1 << req_size));
    assign w_st_strb   = w_size_mask << w_lane;
    assign w_st_wdata  = req_wdata << {w_lane, 3'b000};

    // ------------------------------------------------------------------
    // Store buffer
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]  r_sb_addr [SB_DEPTH];
    logic [DATA_W-1:0]  r_sb_data [SB_DEPTH];
    logic [c_BYTES-1:0] r_sb_strb [SB_DEPTH];
    logic               w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_sb_addr[r_sb_wptr] <= req_addr;
            r_sb_data[r_sb_wptr] <= w_st_wdata;
            r_sb_strb[r_sb_wptr] <= w_st_strb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb_wptr  <= '0;
            r_sb_rptr  <= '0;
            r_sb_count <= '0;
        end else begin
            if (w_push) r_sb_wptr <= r_sb_wptr + 1'b1;
            if (w_pop)  r_sb_rptr <= r_sb_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_sb_count <= r_sb_count + 1'b1;
                2'b01:   r_sb_count <= r_sb_count - 1'b1;
                default: r_sb_count <= r_sb_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write drain FSM
    // ------------------------------------------------------------------
    logic               r_awvalid, r_wvalid, r_bready;
    logic               w_awvalid_nxt, w_wvalid_nxt, w_bready_nxt;
    logic               w_b_done;
    logic [ADDR_W-1:0]  r_awaddr;
    logic [DATA_W-1:0]  r_wdata;
    logic [c_BYTES-1:0] r_wstrb;

    always_comb begin
        w_w_state_nxt = r_w_state;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        w_bready_nxt  = r_bready;
        w_pop         = 1'b0;
        w_b_done      = 1'b0;
        case (r_w_state)
            W_IDLE: begin
                if (r_sb_count != '0) begin
                    w_pop         = 1'b1;
                    w_awvalid_nxt = 1'b1;
                    w_wvalid_nxt  = 1'b1;
                    w_bready_nxt  = 1'b1;
                    w_w_state_nxt = W_BUSY;
                end
            end
            W_BUSY: begin
                if (r_awvalid && awready) w_awvalid_nxt = 1'b0;
                if (r_wvalid && wready)   w_wvalid_nxt  = 1'b0;
                // B is only honoured once both AW and W have been taken
                if (!r_awvalid && !r_wvalid && bvalid && r_bready) begin
                    w_b_done      = 1'b1;
                    w_bready_nxt  = 1'b0;
                    w_w_state_nxt = W_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w_state <= W_IDLE;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_w_state <= w_w_state_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_bready  <= w_bready_nxt;
            if (w_pop) begin
                r_awaddr <= r_sb_addr[r_sb_rptr];
                r_wdata  <= r_sb_data[r_sb_rptr];
                r_wstrb  <= r_sb_strb[r_sb_rptr];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky store error
    // ------------------------------------------------------------------
    logic              r_store_err;
    logic [ADDR_W-1:0] r_store_err_addr;
    logic              w_store_fault;

    assign w_store_fault = w_b_done && (bresp != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_store_err      <= 1'b0;
            r_store_err_addr <= '0;
        end else if (w_store_fault) begin
            r_store_err <= 1'b1;
            if (!r_store_err) r_store_err_addr <= r_awaddr;
        end else if (err_clr) begin
            r_store_err <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Load FSM
    // ------------------------------------------------------------------
    logic                r_arvalid, r_rready;
    logic                w_arvalid_nxt, w_rready_nxt;
    logic                w_ld_done;
    logic [ADDR_W-1:0]   r_araddr;
    logic [c_LANE_W-1:0] r_ld_lane;
    logic [1:0]          r_ld_size;
    logic                r_ld_signed;

    always_comb begin
        w_r_state_nxt = r_r_state;
        w_arvalid_nxt = r_arvalid;
        w_rready_nxt  = r_rready;
        w_ld_done     = 1'b0;
        case (r_r_state)
            R_IDLE: begin
                if (w_ld_go) begin
                    w_arvalid_nxt = 1'b1;
                    w_rready_nxt  = 1'b1;
                    w_r_state_nxt = R_AR;
                end
            end
            R_AR: begin
                if (arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_r_state_nxt = R_DATA;
                    if (rvalid && r_rready) begin
                        w_ld_done     = 1'b1;
                        w_rready_nxt  = 1'b0;
                        w_r_state_nxt = R_IDLE;
                    end
                end
            end
            R_DATA: begin
                if (rvalid && r_rready) begin
                    w_ld_done     = 1'b1;
                    w_rready_nxt  = 1'b0;
                    w_r_state_nxt = R_IDLE;
                end
            end
            default: w_r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r_state   <= R_IDLE;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_araddr    <= '0;
            r_ld_lane   <= '0;
            r_ld_size   <= '0;
            r_ld_signed <= 1'b0;
        end else begin
            r_r_state <= w_r_state_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
            if (w_ld_go) begin
                r_araddr    <= req_addr;
                r_ld_lane   <= w_lane;
                r_ld_size   <= req_size;
                r_ld_signed <= req_signed;
            end
        end
    end

    // Field extraction: shift the lane down, then mask to 8<<size bits
    logic [DATA_W-1:0] w_rshift, w_fmask, w_fmsb, w_ext;
    logic [6:0]        w_fbits;
    logic              w_fsign;

    assign w_rshift = rdata >> {r_ld_lane, 3'b000};
    assign w_fbits  = 7'd8 << r_ld_size;
    assign w_fmask  = ~({DATA_W{1'b1}} << w_fbits);
    assign w_fmsb   = w_fmask ^ (w_fmask >> 1);
    assign w_fsign  = r_ld_signed && |(w_rshift & w_fmsb);
    assign w_ext    = w_fsign ? (w_rshift | ~w_fmask) : (w_rshift & w_fmask);

    // ------------------------------------------------------------------
    // Response pulse
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            if (w_accept && (req_wen || w_bad)) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= w_bad;
            end else if (w_ld_done) begin
                r_resp_valid <= 1'b1;
                r_resp_rdata <= w_ext;
                r_resp_err   <= (rresp != 2'b00);
            end
        end
    end

    assign resp_valid     = r_resp_valid;
    assign resp_rdata     = r_resp_rdata;
    assign resp_err       = r_resp_err;
    assign store_err      = r_store_err;
    assign store_err_addr = r_store_err_addr;
    assign sb_empty       = w_sb_empty;
    assign awaddr         = r_awaddr;
    assign awvalid        = r_awvalid;
    assign wdata          = r_wdata;
    assign wstrb          = r_wstrb;
    assign wvalid         = r_wvalid;
    assign bready         = r_bready;
    assign araddr         = r_araddr;
    assign arvalid        = r_arvalid;
    assign rready         = r_rready;

endmodule
`default_nettype wire
